// File: rtl/mc_control.sv
// Multi-cycle datapath controller: sequences fetch, decode, memory, ALU and
// branch/jump steps, and decodes the datapath controls from the current state.
module mc_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  input  logic       Zero,
  input  logic       Neg,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur;
  logic [5:0] op_q;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur  <= S_FETCH;
      op_q <= 6'd0;
    end else begin
      case (cur)
        S_FETCH:  cur <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          op_q <= Opcode;
          case (Opcode)
            OP_LW, OP_SW:                     cur <= S_MEMADR;
            OP_R:                             cur <= S_REXEC;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: cur <= S_IEXEC;
            OP_BEQ, OP_BNE, OP_BGTZ:          cur <= S_BRANCH;
            OP_J:                             cur <= S_JUMP;
            default:                          cur <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (op_q == OP_LW)      cur <= S_MEMRD;
          else if (op_q == OP_SW) cur <= S_MEMWR;
          else                    cur <= S_FETCH;
        end
        S_MEMRD:  cur <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  cur <= S_FETCH;
        S_MEMWR:  cur <= mem_ready ? S_FETCH : S_MEMWR;
        S_REXEC:  cur <= S_RWB;
        S_RWB:    cur <= S_FETCH;
        S_IEXEC:  cur <= S_IWB;
        S_IWB:    cur <= S_FETCH;
        S_BRANCH: cur <= S_FETCH;
        S_JUMP:   cur <= S_FETCH;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    ALUOp    = 3'b000;
    illegal  = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
          OP_BEQ, OP_BNE, OP_BGTZ, OP_J: illegal = 1'b0;
          default:                        illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_SLTI: ALUOp = 3'b111;
          OP_ANDI: ALUOp = 3'b100;
          OP_ORI:  ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
      end
      S_IWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        PCSource = 2'b01;
        ALUOp    = (op_q == OP_BGTZ) ? 3'b110 : 3'b001;
        // Branch decision uses the ALU flags of this very cycle.
        PCWrite  = ((op_q == OP_BEQ)  &  Zero) |
                   ((op_q == OP_BNE)  & ~Zero) |
                   ((op_q == OP_BGTZ) & ~Zero & ~Neg);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each instruction is expanded into its expected
// per-cycle control vectors, which a negedge compare process checks against the DUT.
module tb_mc_control;

  localparam logic [5:0] R_T  = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] BGTZ = 6'b000111;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, mr, mw, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    int         fs, ms;
    logic       z, n;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready, Zero, Neg;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       illegal;
  logic [3:0] state;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {state, PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_vector t=%0t exp_state=%0d actual=%h required=%h",
                 $time, e.st, a, e);
      end
    end
  end

  function automatic exp_t mk(input int st);
    exp_t e;
    e    = '0;
    e.st = 4'(st);
    return e;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t fetch_exp(input logic ready, input logic in_reset);
    exp_t e;
    e     = mk(0);
    e.asb = 2'b01;
    e.mr  = !in_reset;
    e.irw = ready && !in_reset;
    e.pcw = ready && !in_reset;
    return e;
  endfunction

  task automatic do_instr(input vec_t v);
    exp_t e;
    int   cyc;
    logic taken;
    cyc    = 0;
    Opcode = v.op;
    Zero   = v.z;
    Neg    = v.n;
    for (int i = 0; i <= v.fs; i++) begin
      mem_ready = (i == v.fs);
      step(fetch_exp(mem_ready, 1'b0));
      cyc++;
    end
    mem_ready = 1'b1;
    e     = mk(1);
    e.asb = 2'b11;
    e.ill = !(v.op inside {R_T, LW, SW, BEQ, BNE, BGTZ, ADDI, SLTI, ANDI, ORI, J});
    step(e);
    cyc++;
    // Scramble the opcode: later steps must rely on the captured copy.
    Opcode = ~v.op;
    case (v.op)
      LW, SW: begin
        e = mk(2); e.asa = 1; e.asb = 2'b10;
        step(e); cyc++;
        for (int i = 0; i <= v.ms; i++) begin
          mem_ready = (i == v.ms);
          e = mk(v.op == LW ? 3 : 5);
          e.iord = 1;
          if (v.op == LW) e.mr = 1; else e.mw = 1;
          step(e); cyc++;
        end
        mem_ready = 1'b1;
        if (v.op == LW) begin
          e = mk(4); e.rw = 1; e.m2r = 1;
          step(e); cyc++;
        end
      end
      R_T: begin
        e = mk(6); e.asa = 1; e.aop = 3'b010;
        step(e); cyc++;
        e = mk(7); e.rw = 1; e.rdst = 1;
        step(e); cyc++;
      end
      ADDI, SLTI, ANDI, ORI: begin
        e = mk(8); e.asa = 1; e.asb = 2'b10;
        e.aop = (v.op == SLTI) ? 3'b111 : (v.op == ANDI) ? 3'b100 :
                (v.op == ORI) ? 3'b101 : 3'b000;
        step(e); cyc++;
        e = mk(9); e.rw = 1;
        step(e); cyc++;
      end
      BEQ, BNE, BGTZ: begin
        if (v.op == BEQ)      taken = v.z;
        else if (v.op == BNE) taken = !v.z;
        else                  taken = !v.z && !v.n;
        e = mk(10); e.asa = 1; e.pcs = 2'b01; e.pcw = taken;
        e.aop = (v.op == BGTZ) ? 3'b110 : 3'b001;
        step(e); cyc++;
      end
      J: begin
        e = mk(11); e.pcw = 1; e.pcs = 2'b10;
        step(e); cyc++;
      end
      default: ;
    endcase
    n_checks++;
    if (cyc != v.lat) begin
      n_fail++;
      $display("FAIL latency op=%b actual=%0d required=%0d", v.op, cyc, v.lat);
    end
  endtask

  vec_t vecs[$];

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    Opcode    = 6'd0;
    mem_ready = 1'b0;
    Zero      = 1'b0;
    Neg       = 1'b0;
    @(posedge clk);
    #1;
    step(fetch_exp(1'b0, 1'b1));
    rst_n = 1'b1;

    vecs.push_back('{LW,   0, 0, 0, 0, 5});
    vecs.push_back('{R_T,  2, 0, 0, 0, 6});
    vecs.push_back('{BGTZ, 0, 0, 0, 0, 3});
    vecs.push_back('{BGTZ, 0, 0, 0, 1, 3});
    vecs.push_back('{ORI,  0, 0, 0, 0, 4});
    vecs.push_back('{SLTI, 0, 0, 0, 0, 4});
    vecs.push_back('{BAD,  0, 0, 0, 0, 2});
    vecs.push_back('{SW,   0, 2, 0, 0, 6});
    vecs.push_back('{LW,   1, 1, 0, 0, 7});
    vecs.push_back('{BEQ,  0, 0, 1, 0, 3});
    vecs.push_back('{BEQ,  0, 0, 0, 1, 3});
    vecs.push_back('{BNE,  0, 0, 0, 0, 3});
    vecs.push_back('{BNE,  0, 0, 1, 0, 3});
    vecs.push_back('{ADDI, 0, 0, 0, 0, 4});
    vecs.push_back('{ANDI, 1, 0, 0, 0, 5});
    vecs.push_back('{J,    0, 0, 0, 0, 3});
    vecs.push_back('{BGTZ, 0, 0, 1, 0, 3});
    vecs.push_back('{SW,   0, 0, 0, 0, 4});
    foreach (vecs[i]) do_instr(vecs[i]);

    // Reset asserted while a load waits on memory.
    Opcode = LW;
    mem_ready = 1'b1;
    step(fetch_exp(1'b1, 1'b0));
    e = mk(1); e.asb = 2'b11;
    step(e);
    e = mk(2); e.asa = 1; e.asb = 2'b10;
    step(e);
    mem_ready = 1'b0;
    e = mk(3); e.mr = 1; e.iord = 1;
    step(e);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (MemRead !== 1'b0 || state !== 4'd3) begin
      n_fail++;
      $display("FAIL reset_gating MemRead=%b state=%0d required MemRead=0 state=3",
               MemRead, state);
    end
    e = mk(3); e.iord = 1;
    step(e);
    step(fetch_exp(1'b0, 1'b1));
    rst_n = 1'b1;
    do_instr('{LW, 0, 0, 0, 0, 5});

    repeat (2) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: none; opcode and ALUOp encodings are fixed by this document.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 Opcode  in  6  instruction[31:26] from IR, valid from DECODE onward.
REQ-005 mem_ready  in  1  memory handshake; access completes in the cycle it is 1.
REQ-006 Zero  in  1  ALU result == 0.
REQ-007 Neg  in  1  ALU result bit 31.
REQ-008 PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-009 ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-010 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 ALUOp  out  3  drives ALUControl: 000 add, 001 sub, 010 R-type funct, 100 and, 101 or, 111 slt, 110 bgtz.
REQ-012 illegal  out  1  one-cycle pulse on unknown opcode.
REQ-013 state  out  4  current state code, debug.

Function
REQ-014 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11; codes 12-15 go to FETCH next cycle with all outputs 0.
REQ-015 Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, BGTZ 000111, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, J 000010.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; Opcode captured into internal op_q; next: LW/SW->MEMADR, R->REXEC, ADDI/SLTI/ANDI/ORI->IEXEC, BEQ/BNE/BGTZ->BRANCH, J->JUMP, other->FETCH with illegal=1 this cycle.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; op_q LW->MEMRD, SW->MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then MEMWB.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-022 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->RWB.
REQ-023 RWB: RegWrite=1, RegDst=1, MemtoReg=0; ->FETCH.
REQ-024 IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp 000 ADDI, 111 SLTI, 100 ANDI, 101 ORI; ->IWB.
REQ-025 IWB: RegWrite=1, RegDst=0, MemtoReg=0; ->FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, PCSource=01; ALUOp 001 for BEQ/BNE, 110 for BGTZ; PCWrite = (BEQ&Zero)|(BNE&~Zero)|(BGTZ&~Zero&~Neg), combinational in this cycle; ->FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10; ->FETCH.
REQ-028 Every output not listed for a state is 0; ALUOp defaults 000.
REQ-029 Latency in clk cycles with mem_ready=1: LW 5, SW 4, R/I-type 4, branch 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.
REQ-030 Opcode changes after DECODE have no effect; op_q is used.

Reset
REQ-031 Rising clk with rst_n=0: state<=FETCH, op_q<=0, from any state including mid-wait.
REQ-032 While rst_n=0, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, illegal forced 0 combinationally.
REQ-033 First cycle after rst_n rises: FETCH outputs per REQ-016.

Verification
REQ-034 Reset then Opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-035 R-type, mem_ready=0 for 2 cycles in FETCH -> state 0 held 3 cycles, IRWrite=1 only on third; REXEC ALUOp=010.
REQ-036 BGTZ (000111) with Zero=0,Neg=0 -> BRANCH ALUOp=110, PCWrite=1, PCSource=01; repeat Neg=1 -> PCWrite=0.
REQ-037 ORI (001101) then SLTI (001010) -> IEXEC ALUOp=101 then 111, RegWrite in IWB only.
REQ-038 Opcode=111111 -> illegal=1 for one cycle in DECODE, next state 0, no write enables asserted.
REQ-039 rst_n=0 during MEMRD wait -> all enables 0 immediately, state=0 after edge.
